// File: rtl/chroma_key_compositor.sv
// chroma_key_compositor: green-screen compositor placed between the camera
// colour converter and the display controller. Each valid camera pixel is
// tested against a key colour within a per-channel tolerance. Depending on the
// mode, the block outputs the camera pixel, the background pixel, or a key mask.
// The key colour can be set manually or learned from a square window of a frame.
// The number of keyed pixels in the last completed frame is reported.
// Two-stage pipeline: S1 registers pixel/bg/|pix-key|, S2 decides and registers.
// Optional feature macro: CHROMA_SOFT_EDGE_EN (blend near-key pixels in mode 1).
`timescale 1ns/1ps

module chroma_key_compositor #(
    parameter int unsigned COLOR_W  = 12,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WIN_X0   = 304,
    parameter int unsigned WIN_Y0   = 224,
    parameter int unsigned WIN_LOG2 = 4,
    parameter int unsigned KCNT_W   = 20
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    input  logic               iDataValid,
    input  logic               iFrameValid,
    input  logic [CNT_W-1:0]   iX_Counter,
    input  logic [CNT_W-1:0]   iY_Counter,
    input  logic [COLOR_W-1:0] iBgRed,
    input  logic [COLOR_W-1:0] iBgGreen,
    input  logic [COLOR_W-1:0] iBgBlue,
    input  logic [COLOR_W-1:0] iKeyR,
    input  logic [COLOR_W-1:0] iKeyG,
    input  logic [COLOR_W-1:0] iKeyB,
    input  logic [COLOR_W-1:0] iTol,
    input  logic [1:0]         iMode,
    input  logic               iLearn,
    input  logic               iUseLearned,
    output logic [COLOR_W-1:0] oRed,
    output logic [COLOR_W-1:0] oGreen,
    output logic [COLOR_W-1:0] oBlue,
    output logic               oDataValid,
    output logic               oKeyed,
    output logic [KCNT_W-1:0]  oKeyCount,
    output logic               oLearnBusy,
    output logic               oLearnValid,
    output logic               oLearnErr
);

    localparam int unsigned SHIFT   = 2 * WIN_LOG2;
    localparam int unsigned ACC_W   = COLOR_W + SHIFT;
    localparam int unsigned PCNT_W  = SHIFT + 1;
    localparam int unsigned WIN_N   = 1 << WIN_LOG2;
    localparam int unsigned WIN_PIX = 1 << SHIFT;
    localparam int unsigned CMP_W   = CNT_W + 1;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] g;
        logic [ACC_W-1:0] b;
    } acc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DIV   = 2'd3
    } state_t;

    function automatic logic [COLOR_W-1:0] abs_diff(input logic [COLOR_W-1:0] a,
                                                     input logic [COLOR_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // ---------------------------------------------------------------- signals
    rgb_t               cam_c, bg_c, key_man_c, key_act_c;
    rgb_t               cam_q, bg_q, diff_q;
    logic               s1_valid_q;
    rgb_t               learned_q, learned_d;
    acc_t               acc_q, acc_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    state_t             state_q, state_d;
    logic               lvalid_d, lerr_d, busy_d;
    logic               fv_q;
    logic               fv_rise_c, fv_fall_c;
    logic               in_win_c;
    logic               keyed_c;
    rgb_t               pix_c;
    logic [KCNT_W-1:0]  kcnt_q;
    logic [KCNT_W-1:0]  ksum_c;
    logic               kinc_c;
    logic [CMP_W-1:0]   x_ext_c, y_ext_c;

    assign cam_c     = {iRed, iGreen, iBlue};
    assign bg_c      = {iBgRed, iBgGreen, iBgBlue};
    assign key_man_c = {iKeyR, iKeyG, iKeyB};
    assign fv_rise_c = iFrameValid & ~fv_q;
    assign fv_fall_c = fv_q & ~iFrameValid;

    // Active key selection: the learned key only once it is valid
    always_comb begin
        key_act_c = key_man_c;
        if (iUseLearned && oLearnValid) begin
            key_act_c = learned_q;
        end
    end

    // S1: capture pixel, background and per-channel distance to the key
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_valid_q <= 1'b0;
            cam_q      <= '0;
            bg_q       <= '0;
            diff_q     <= '0;
        end else begin
            s1_valid_q <= iDataValid;
            if (iDataValid) begin
                cam_q    <= cam_c;
                bg_q     <= bg_c;
                diff_q.r <= abs_diff(iRed,   key_act_c.r);
                diff_q.g <= abs_diff(iGreen, key_act_c.g);
                diff_q.b <= abs_diff(iBlue,  key_act_c.b);
            end
        end
    end

    // S2: key decision
    assign keyed_c = (diff_q.r <= iTol) && (diff_q.g <= iTol) && (diff_q.b <= iTol);

`ifdef CHROMA_SOFT_EDGE_EN
    logic [COLOR_W:0] tol2_c;
    logic             near_c;
    rgb_t             avg_c;
    logic [COLOR_W:0] sum_r_c, sum_g_c, sum_b_c;

    // Near-key band and camera/background average for soft edges
    always_comb begin
        tol2_c  = {iTol, 1'b0};
        near_c  = ({1'b0, diff_q.r} <= tol2_c) &&
                  ({1'b0, diff_q.g} <= tol2_c) &&
                  ({1'b0, diff_q.b} <= tol2_c);
        sum_r_c = {1'b0, cam_q.r} + {1'b0, bg_q.r};
        sum_g_c = {1'b0, cam_q.g} + {1'b0, bg_q.g};
        sum_b_c = {1'b0, cam_q.b} + {1'b0, bg_q.b};
        avg_c.r = sum_r_c[COLOR_W:1];
        avg_c.g = sum_g_c[COLOR_W:1];
        avg_c.b = sum_b_c[COLOR_W:1];
    end
`endif

    // S2: output select per mode
    always_comb begin
        pix_c = cam_q;
        case (iMode)
            2'd0: pix_c = cam_q;
            2'd1: begin
                if (keyed_c) begin
                    pix_c = bg_q;
`ifdef CHROMA_SOFT_EDGE_EN
                end else if (near_c) begin
                    pix_c = avg_c;
`endif
                end else begin
                    pix_c = cam_q;
                end
            end
            2'd2: pix_c = keyed_c ? {(3 * COLOR_W){1'b1}} : {(3 * COLOR_W){1'b0}};
            2'd3: pix_c = bg_q;
            default: pix_c = cam_q;
        endcase
    end

    // S2 output registers; colour holds while no valid pixel
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDataValid <= 1'b0;
            oKeyed     <= 1'b0;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
        end else begin
            oDataValid <= s1_valid_q;
            oKeyed     <= s1_valid_q & keyed_c;
            if (s1_valid_q) begin
                oRed   <= pix_c.r;
                oGreen <= pix_c.g;
                oBlue  <= pix_c.b;
            end
        end
    end

    // Saturating keyed-pixel increment; the frame-end cycle still counts
    assign kinc_c = s1_valid_q & keyed_c & (iFrameValid | fv_q);
    assign ksum_c = (!kinc_c || (kcnt_q == {KCNT_W{1'b1}})) ? kcnt_q
                                                             : kcnt_q + KCNT_W'(1);

    // Per-frame keyed count, latched and cleared on frame-valid fall
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fv_q      <= 1'b0;
            kcnt_q    <= '0;
            oKeyCount <= '0;
        end else begin
            fv_q <= iFrameValid;
            if (fv_fall_c) begin
                oKeyCount <= ksum_c;
                kcnt_q    <= '0;
            end else if (iFrameValid) begin
                kcnt_q <= ksum_c;
            end
        end
    end

    // Learn window membership
    assign x_ext_c  = CMP_W'(iX_Counter);
    assign y_ext_c  = CMP_W'(iY_Counter);
    assign in_win_c = (x_ext_c >= CMP_W'(WIN_X0)) && (x_ext_c < CMP_W'(WIN_X0 + WIN_N)) &&
                      (y_ext_c >= CMP_W'(WIN_Y0)) && (y_ext_c < CMP_W'(WIN_Y0 + WIN_N));

    // Learn FSM next-state and datapath
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pcnt_d    = pcnt_q;
        learned_d = learned_q;
        lvalid_d  = oLearnValid;
        lerr_d    = oLearnErr;
        case (state_q)
            ST_IDLE: begin
                if (iLearn) begin
                    state_d = ST_ARM;
                    acc_d   = '0;
                    pcnt_d  = '0;
                    lerr_d  = 1'b0;
                end
            end
            ST_ARM: begin
                if (fv_rise_c) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!iFrameValid) begin
                    state_d = ST_IDLE;
                    lerr_d  = 1'b1;
                end else if (iDataValid && in_win_c) begin
                    acc_d.r = acc_q.r + ACC_W'(iRed);
                    acc_d.g = acc_q.g + ACC_W'(iGreen);
                    acc_d.b = acc_q.b + ACC_W'(iBlue);
                    pcnt_d  = pcnt_q + PCNT_W'(1);
                    if (pcnt_d == PCNT_W'(WIN_PIX)) begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                learned_d.r = COLOR_W'(acc_q.r >> SHIFT);
                learned_d.g = COLOR_W'(acc_q.g >> SHIFT);
                learned_d.b = COLOR_W'(acc_q.b >> SHIFT);
                lvalid_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Learn FSM state and result registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            pcnt_q      <= '0;
            learned_q   <= '0;
            oLearnValid <= 1'b0;
            oLearnErr   <= 1'b0;
            oLearnBusy  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pcnt_q      <= pcnt_d;
            learned_q   <= learned_d;
            oLearnValid <= lvalid_d;
            oLearnErr   <= lerr_d;
            oLearnBusy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_chroma_key_compositor.sv
// Testbench for chroma_key_compositor: vector table, randomized bursts against
// a reference model, frame counting, key learning and reset sequences.
`timescale 1ns/1ps

module tb_chroma_key_compositor;

    localparam int ONES = 4095;
    localparam int WX0  = 304;
    localparam int WY0  = 224;
`ifdef CHROMA_SOFT_EDGE_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic        clk, rst;
    logic [11:0] r, g, b, bgr, bgg, bgb, kr, kg, kb, tol;
    logic        dv, fv, learn, use_l;
    logic [15:0] xc, yc;
    logic [1:0]  mode;

    logic [11:0] o_r, o_g, o_b;
    logic        o_dv, o_keyed, o_busy, o_lvalid, o_lerr;
    logic [19:0] o_kcnt;

    logic [11:0] d8_r, d8_g, d8_b;
    logic        d8_dv, d8_keyed, d8_busy, d8_lvalid, d8_lerr;
    logic [7:0]  d8_kcnt;
    logic        d8_unused;
    assign d8_unused = ^{d8_r, d8_g, d8_b, d8_dv, d8_keyed, d8_busy, d8_lvalid, d8_lerr};

    int total = 0;
    int bad   = 0;

    chroma_key_compositor u_dut (
        .iCLK(clk), .iRST(rst),
        .iRed(r), .iGreen(g), .iBlue(b),
        .iDataValid(dv), .iFrameValid(fv),
        .iX_Counter(xc), .iY_Counter(yc),
        .iBgRed(bgr), .iBgGreen(bgg), .iBgBlue(bgb),
        .iKeyR(kr), .iKeyG(kg), .iKeyB(kb),
        .iTol(tol), .iMode(mode), .iLearn(learn), .iUseLearned(use_l),
        .oRed(o_r), .oGreen(o_g), .oBlue(o_b),
        .oDataValid(o_dv), .oKeyed(o_keyed), .oKeyCount(o_kcnt),
        .oLearnBusy(o_busy), .oLearnValid(o_lvalid), .oLearnErr(o_lerr)
    );

    chroma_key_compositor #(.KCNT_W(8)) u_dut8 (
        .iCLK(clk), .iRST(rst),
        .iRed(r), .iGreen(g), .iBlue(b),
        .iDataValid(dv), .iFrameValid(fv),
        .iX_Counter(xc), .iY_Counter(yc),
        .iBgRed(bgr), .iBgGreen(bgg), .iBgBlue(bgb),
        .iKeyR(kr), .iKeyG(kg), .iKeyB(kb),
        .iTol(tol), .iMode(mode), .iLearn(learn), .iUseLearned(use_l),
        .oRed(d8_r), .oGreen(d8_g), .oBlue(d8_b),
        .oDataValid(d8_dv), .oKeyed(d8_keyed), .oKeyCount(d8_kcnt),
        .oLearnBusy(d8_busy), .oLearnValid(d8_lvalid), .oLearnErr(d8_lerr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int r, g, b;
        bit k;
    } exp_t;

    typedef struct {
        int cr, cg, cb, br, bg, bb, kr, kg, kb, t, m;
        int er, eg, eb;
        bit ek;
    } vec_t;

    typedef struct {
        bit dv;
        int cr, cg, cb, br, bg, bb;
    } rin_t;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: distance to key, tolerance test, per-mode selection
    function automatic exp_t ref_pix(input int cr, cg, cb, br, bgv, bb,
                                     input int kr_, kg_, kb_, t, m);
        exp_t e;
        int   dmax;
        dmax = iabs(cr - kr_);
        if (iabs(cg - kg_) > dmax) dmax = iabs(cg - kg_);
        if (iabs(cb - kb_) > dmax) dmax = iabs(cb - kb_);
        e.k = (dmax <= t);
        case (m)
            0: begin e.r = cr; e.g = cg; e.b = cb; end
            1: begin
                if (e.k) begin
                    e.r = br; e.g = bgv; e.b = bb;
                end else if (SOFT && dmax <= 2 * t) begin
                    e.r = (cr + br) / 2; e.g = (cg + bgv) / 2; e.b = (cb + bb) / 2;
                end else begin
                    e.r = cr; e.g = cg; e.b = cb;
                end
            end
            2: begin
                e.r = e.k ? ONES : 0; e.g = e.r; e.b = e.r;
            end
            default: begin e.r = br; e.g = bgv; e.b = bb; end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int cr, cg, cb, br, bgv, bb);
        r = 12'(cr); g = 12'(cg); b = 12'(cb);
        bgr = 12'(br); bgg = 12'(bgv); bgb = 12'(bb);
    endtask

    task automatic set_key(input int k_r, k_g, k_b, t, m);
        kr = 12'(k_r); kg = 12'(k_g); kb = 12'(k_b);
        tol = 12'(t); mode = 2'(m);
    endtask

    // One isolated pixel, checked two cycles later
    task automatic apply_one(input string name, input int cr, cg, cb, br, bgv, bb,
                             input int er, eg, eb, input bit ek);
        set_pix(cr, cg, cb, br, bgv, bb);
        dv = 1'b1;
        tick();
        dv = 1'b0;
        tick();
        check({name, "_dv"}, 32'(o_dv), 32'd1);
        check({name, "_r"},  32'(o_r), 32'(er));
        check({name, "_g"},  32'(o_g), 32'(eg));
        check({name, "_b"},  32'(o_b), 32'(eb));
        check({name, "_key"}, 32'(o_keyed), 32'(ek));
    endtask

    task automatic pulse_learn();
        learn = 1'b1;
        tick();
        learn = 1'b0;
    endtask

    // Partial raster around the learn window; optional abort and busy re-request
    task automatic learn_frame(input int pat, input int abort_row, input bit poke);
        bit inw;
        fv = 1'b1;
        dv = 1'b0;
        tick();
        for (int y = 220; y < 244; y++) begin
            for (int x = 300; x < 324; x++) begin
                xc = 16'(x);
                yc = 16'(y);
                if (abort_row >= 0 && y == WY0 + abort_row && x == 308) begin
                    fv = 1'b0;
                    dv = 1'b0;
                    tick();
                    return;
                end
                inw = (x >= WX0) && (x < WX0 + 16) && (y >= WY0) && (y < WY0 + 16);
                if (inw && pat == 0)
                    set_pix(20, 3000, 40, 0, 0, 0);
                else if (inw)
                    set_pix(((x % 2) == 1) ? 101 : 100, 500, 600, 0, 0, 0);
                else
                    set_pix(int'($urandom_range(0, ONES)), int'($urandom_range(0, ONES)),
                            int'($urandom_range(0, ONES)), 0, 0, 0);
                dv = 1'b1;
                learn = poke && (y == WY0 + 5) && (x == 310);
                tick();
            end
        end
        learn = 1'b0;
        dv = 1'b0;
        tick();
        fv = 1'b0;
        tick();
        tick();
    endtask

    // Frame with n pixels, those with (i % 10) < kper keyed against (0,4095,0)/64
    task automatic count_frame(input int n, input int kper, input int exp20, input int exp8,
                               input string name);
        set_key(0, ONES, 0, 64, 1);
        xc = '0;
        yc = '0;
        fv = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            if ((i % 10) < kper) set_pix(10, 4050, 30, 1, 2, 3);
            else set_pix(2000, 100, 100, 1, 2, 3);
            dv = 1'b1;
            tick();
        end
        dv = 1'b0;
        tick();
        tick();
        fv = 1'b0;
        tick();
        tick();
        check({name, "_kcnt"}, 32'(o_kcnt), 32'(exp20));
        check({name, "_kcnt8"}, 32'(d8_kcnt), 32'(exp8));
    endtask

    vec_t tbl[10];
    rin_t recs[64];

    initial begin
        exp_t e;
        int   er, eg, eb, n;
        bit   known;
        int   k_r, k_g, k_b, t;

        rst = 1'b1; dv = 1'b0; fv = 1'b0; learn = 1'b0; use_l = 1'b0;
        xc = '0; yc = '0;
        set_pix(0, 0, 0, 0, 0, 0);
        set_key(0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst_dv", 32'(o_dv), 32'd0);
        check("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check("rst_keyed", 32'(o_keyed), 32'd0);
        check("rst_kcnt", 32'(o_kcnt), 32'd0);
        check("rst_learn", 32'({o_busy, o_lvalid, o_lerr}), 32'd0);
        rst = 1'b0;
        tick();

        // Vector table
        tbl[0] = '{10, 4050, 30, 100, 200, 300, 0, ONES, 0, 64, 1, 100, 200, 300, 1'b1};
        tbl[1] = '{10, 3900, 30, 100, 200, 300, 0, ONES, 0, 64, 1, 10, 3900, 30, 1'b0};
        tbl[2] = '{10, 4050, 30, 100, 200, 300, 0, ONES, 0, 64, 0, 10, 4050, 30, 1'b1};
        tbl[3] = '{10, 4050, 30, 100, 200, 300, 0, ONES, 0, 64, 2, ONES, ONES, ONES, 1'b1};
        tbl[4] = '{10, 4050, 30, 100, 200, 300, 0, ONES, 0, 64, 3, 100, 200, 300, 1'b1};
        tbl[5] = '{10, 3900, 30, 100, 200, 300, 0, ONES, 0, 64, 2, 0, 0, 0, 1'b0};
        tbl[6] = '{150, 50, 100, 7, 8, 9, 100, 100, 100, 50, 1, 7, 8, 9, 1'b1};
        tbl[7] = '{151, 50, 100, 7, 8, 9, 100, 100, 100, 50, 2, 0, 0, 0, 1'b0};
        tbl[8] = '{123, 456, 789, 1, 2, 3, 123, 456, 789, 0, 2, ONES, ONES, ONES, 1'b1};
        tbl[9] = '{4000, 0, 5, 11, 22, 33, 0, ONES, 0, 64, 3, 11, 22, 33, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_key(tbl[i].kr, tbl[i].kg, tbl[i].kb, tbl[i].t, tbl[i].m);
            apply_one($sformatf("vec%0d", i), tbl[i].cr, tbl[i].cg, tbl[i].cb,
                      tbl[i].br, tbl[i].bg, tbl[i].bb,
                      tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].ek);
        end

`ifdef CHROMA_SOFT_EDGE_EN
        set_key(100, 100, 100, 64, 1);
        apply_one("soft", 200, 100, 100, 100, 100, 100, 150, 100, 100, 1'b0);
`endif

        // Randomized bursts, one mode/key/tolerance per burst
        for (int burst = 0; burst < 8; burst++) begin
            k_r = int'($urandom_range(0, ONES));
            k_g = int'($urandom_range(0, ONES));
            k_b = int'($urandom_range(0, ONES));
            t   = int'($urandom_range(0, 300));
            set_key(k_r, k_g, k_b, t, burst % 4);
            for (int i = 0; i < 64; i++) begin
                recs[i].dv = ($urandom_range(0, 3) != 0);
                recs[i].br = int'($urandom_range(0, ONES));
                recs[i].bg = int'($urandom_range(0, ONES));
                recs[i].bb = int'($urandom_range(0, ONES));
                if ($urandom_range(0, 1) == 1) begin
                    recs[i].cr = k_r + int'($urandom_range(0, 2 * t + 2)) - (t + 1);
                    recs[i].cg = k_g + int'($urandom_range(0, 2 * t + 2)) - (t + 1);
                    recs[i].cb = k_b + int'($urandom_range(0, 2 * t + 2)) - (t + 1);
                    recs[i].cr = (recs[i].cr < 0) ? 0 : (recs[i].cr > ONES) ? ONES : recs[i].cr;
                    recs[i].cg = (recs[i].cg < 0) ? 0 : (recs[i].cg > ONES) ? ONES : recs[i].cg;
                    recs[i].cb = (recs[i].cb < 0) ? 0 : (recs[i].cb > ONES) ? ONES : recs[i].cb;
                end else begin
                    recs[i].cr = int'($urandom_range(0, ONES));
                    recs[i].cg = int'($urandom_range(0, ONES));
                    recs[i].cb = int'($urandom_range(0, ONES));
                end
            end
            known = 1'b0;
            er = 0; eg = 0; eb = 0;
            for (int i = 0; i < 66; i++) begin
                if (i >= 2) begin
                    e.k = 1'b0;
                    if (recs[i-2].dv) begin
                        e = ref_pix(recs[i-2].cr, recs[i-2].cg, recs[i-2].cb,
                                    recs[i-2].br, recs[i-2].bg, recs[i-2].bb,
                                    k_r, k_g, k_b, t, burst % 4);
                        er = e.r; eg = e.g; eb = e.b;
                        known = 1'b1;
                    end
                    check("rnd_dv", 32'(o_dv), 32'(recs[i-2].dv));
                    check("rnd_keyed", 32'(o_keyed), 32'(recs[i-2].dv && e.k));
                    if (known) begin
                        check("rnd_r", 32'(o_r), 32'(er));
                        check("rnd_g", 32'(o_g), 32'(eg));
                        check("rnd_b", 32'(o_b), 32'(eb));
                    end
                end
                if (i < 64) begin
                    set_pix(recs[i].cr, recs[i].cg, recs[i].cb, recs[i].br, recs[i].bg, recs[i].bb);
                    dv = recs[i].dv;
                end else begin
                    dv = 1'b0;
                end
                tick();
            end
        end

        // Keyed-pixel count per frame, saturation, clear, frame-end pixel
        count_frame(1000, 3, 300, 255, "frame300");
        count_frame(0, 0, 0, 0, "frame_empty");

        // Learn: constant window, with an ignored re-request while busy
        set_key(0, 0, 0, 0, 0);
        xc = '0; yc = '0;
        pulse_learn();
        check("learn1_busy", 32'(o_busy), 32'd1);
        check("learn1_valid0", 32'(o_lvalid), 32'd0);
        tick();
        learn_frame(0, -1, 1'b1);
        check("learn1_busy_done", 32'(o_busy), 32'd0);
        check("learn1_valid", 32'(o_lvalid), 32'd1);
        check("learn1_err", 32'(o_lerr), 32'd0);
        use_l = 1'b1;
        set_key(0, 0, 0, 0, 2);
        apply_one("learn1_hit", 20, 3000, 40, 0, 0, 0, ONES, ONES, ONES, 1'b1);
        apply_one("learn1_miss", 21, 3000, 40, 0, 0, 0, 0, 0, 0, 1'b0);
        use_l = 1'b0;
        apply_one("manual_key", 0, 0, 0, 0, 0, 0, ONES, ONES, ONES, 1'b1);

        // Learn: alternating red 100/101 truncates to 100
        pulse_learn();
        tick();
        learn_frame(1, -1, 1'b0);
        check("learn2_valid", 32'(o_lvalid), 32'd1);
        use_l = 1'b1;
        apply_one("learn2_hit", 100, 500, 600, 0, 0, 0, ONES, ONES, ONES, 1'b1);
        apply_one("learn2_miss", 101, 500, 600, 0, 0, 0, 0, 0, 0, 1'b0);

        // Learn aborted at window row 3 keeps the previous key
        use_l = 1'b0;
        pulse_learn();
        tick();
        learn_frame(0, 3, 1'b0);
        tick();
        check("abort_err", 32'(o_lerr), 32'd1);
        check("abort_valid", 32'(o_lvalid), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        use_l = 1'b1;
        apply_one("abort_keep", 100, 500, 600, 0, 0, 0, ONES, ONES, ONES, 1'b1);
        use_l = 1'b0;
        pulse_learn();
        check("relearn_err_clr", 32'(o_lerr), 32'd0);
        check("relearn_busy", 32'(o_busy), 32'd1);

        // Keyed pixel on the frame-valid falling cycle lands in the latch
        set_key(0, ONES, 0, 64, 1);
        xc = '0; yc = '0;
        fv = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            set_pix(10, 4050, 30, 1, 2, 3);
            dv = 1'b1;
            tick();
        end
        dv = 1'b0;
        fv = 1'b0;
        tick();
        tick();
        check("edge_kcnt", 32'(o_kcnt), 32'd5);
        check("edge_kcnt8", 32'(d8_kcnt), 32'd5);

        // Reset mid-stream
        n = 0;
        set_pix(10, 4050, 30, 1, 2, 3);
        dv = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_dv", 32'(o_dv), 32'd0);
        check("mid_rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check("mid_rst_keyed", 32'(o_keyed), 32'd0);
        check("mid_rst_kcnt", 32'(o_kcnt), 32'd0);
        check("mid_rst_kcnt8", 32'(d8_kcnt), 32'd0);
        check("mid_rst_learn", 32'({o_busy, o_lvalid, o_lerr}), 32'd0);
        dv = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_dv", 32'(o_dv), 32'(n));
        check("post_rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
